// File: rtl/inport_fifo_if.sv
// Producer-side handshake bundle for the CPU in-port FIFO.
// The producer (master) offers a word with ext_valid/ext_data.
// The FIFO (slave) answers with ext_ready.
interface inport_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  ext_valid;
    logic [DATA_WIDTH-1:0] ext_data;
    logic                  ext_ready;

    modport master (
        output ext_valid,
        output ext_data,
        input  ext_ready
    );

    modport slave (
        input  ext_valid,
        input  ext_data,
        output ext_ready
    );
endinterface

// File: rtl/inport_fifo.sv
// In-port FIFO feeding the datapath's inport_ext_input.
// An external producer pushes words through a valid/ready handshake.
// The CPU reads the head word while rd_strobe is high. The word is retired on
// the cycle after the strobe falls, so one `in` consumes exactly one word no
// matter how long the strobe is held.
module inport_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    inport_fifo_if.slave          ext,
    input  logic                  rd_strobe,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] inport_data,
    output logic                  data_avail,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  underrun
);

    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO   = (ADDR_WIDTH + 1)'(0);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO   = ADDR_WIDTH'(0);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [ADDR_WIDTH:0]   count_r;
    logic [DATA_WIDTH-1:0] last_data_r;
    logic                  rd_strobe_q_r;
    logic                  low_seen_r;
    logic                  underrun_r;

    logic                  ext_ready_s;
    logic                  empty_s;
    logic                  push_s;
    logic                  retire_s;
    logic                  pop_s;
    logic                  underrun_set_s;
    logic [DATA_WIDTH-1:0] head_s;
    logic [ADDR_WIDTH:0]   count_next_s;

    // Handshake, retire detection and next occupancy, all from registered state.
    always_comb begin
        ext_ready_s    = (count_r != FULL_COUNT);
        empty_s        = (count_r == CNT_ZERO);
        push_s         = ext.ext_valid && ext_ready_s;
        retire_s       = rd_strobe_q_r && !rd_strobe;
        pop_s          = retire_s && !empty_s;
        underrun_set_s = retire_s && empty_s;
        head_s         = mem_r[rd_ptr_r];
        count_next_s   = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    assign ext.ext_ready = ext_ready_s;
    assign inport_data   = empty_s ? last_data_r : head_s;
    assign data_avail    = !empty_s;
    assign count         = count_r;
    assign underrun      = underrun_r;

    // Storage array: written on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= ext.ext_data;
        end
    end

    // Write pointer advances, wrapping naturally, on each accepted push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= PTR_ZERO;
        end else if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_r <= wr_ptr_r;
        end
    end

    // Read pointer and last retired word update on a non-empty retire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_r    <= PTR_ZERO;
            last_data_r <= '0;
        end else if (pop_s) begin
            rd_ptr_r    <= rd_ptr_r + PTR_ONE;
            last_data_r <= head_s;
        end else begin
            rd_ptr_r    <= rd_ptr_r;
            last_data_r <= last_data_r;
        end
    end

    // Occupancy counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= CNT_ZERO;
        end else begin
            count_r <= count_next_s;
        end
    end

    // Strobe history. A strobe only counts if it started after a low level was
    // seen, so a strobe that straddles reset release never retires a word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_strobe_q_r <= 1'b0;
            low_seen_r    <= 1'b0;
        end else begin
            rd_strobe_q_r <= rd_strobe && (rd_strobe_q_r || low_seen_r);
            low_seen_r    <= low_seen_r || !rd_strobe;
        end
    end

    // Sticky underrun flag; a new underrun beats a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_r <= 1'b0;
        end else if (underrun_set_s) begin
            underrun_r <= 1'b1;
        end else if (clr_err) begin
            underrun_r <= 1'b0;
        end else begin
            underrun_r <= underrun_r;
        end
    end

endmodule

// File: tb/tb_inport_fifo.sv
// Directed bench for inport_fifo: reset, push, full, wraparound,
// simultaneous push/retire, underrun and asynchronous reset mid-strobe.
module tb_inport_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_strobe;
    logic        clr_err;
    logic [31:0] inport_data;
    logic        data_avail;
    logic [2:0]  count;
    logic        underrun;

    int n_checks = 0;
    int n_fails  = 0;

    inport_fifo_if #(.DATA_WIDTH(32)) ext_if ();

    inport_fifo #(.DATA_WIDTH(32), .DEPTH(4), .ADDR_WIDTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .ext         (ext_if.slave),
        .rd_strobe   (rd_strobe),
        .clr_err     (clr_err),
        .inport_data (inport_data),
        .data_avail  (data_avail),
        .count       (count),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Strobe held for n cycles, then dropped; retire happens on the last edge.
    task automatic do_strobe(input int n);
        rd_strobe = 1'b1;
        repeat (n) step();
        rd_strobe = 1'b0;
        step();
    endtask

    task automatic push_word(input logic [31:0] w);
        ext_if.ext_valid = 1'b1;
        ext_if.ext_data  = w;
        step();
        ext_if.ext_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; rd_strobe = 1'b0; clr_err = 1'b0;
        ext_if.ext_valid = 1'b0; ext_if.ext_data = 32'h0;
        #1;
        n_checks++; if (ext_if.ext_ready !== 1'b1) begin n_fails++; $display("FAIL reset_ready: got %b want 1", ext_if.ext_ready); end
        n_checks++; if (data_avail !== 1'b0) begin n_fails++; $display("FAIL reset_avail: got %b want 0", data_avail); end
        n_checks++; if (inport_data !== 32'h0) begin n_fails++; $display("FAIL reset_data: got %h want 0", inport_data); end
        n_checks++; if (count !== 3'd0) begin n_fails++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++; if (underrun !== 1'b0) begin n_fails++; $display("FAIL reset_underrun: got %b want 0", underrun); end
        step(); step();
        reset = 1'b0;
        step(); step();
    endtask

    task automatic test_push_one();
        push_word(32'h1F);
        n_checks++; if (count !== 3'd1) begin n_fails++; $display("FAIL push1_count: got %0d want 1", count); end
        n_checks++; if (data_avail !== 1'b1) begin n_fails++; $display("FAIL push1_avail: got %b want 1", data_avail); end
        n_checks++; if (inport_data !== 32'h0000001F) begin n_fails++; $display("FAIL push1_data: got %h want 1f", inport_data); end
        n_checks++; if (ext_if.ext_ready !== 1'b1) begin n_fails++; $display("FAIL push1_ready: got %b want 1", ext_if.ext_ready); end
        do_strobe(1);
        n_checks++; if (count !== 3'd0) begin n_fails++; $display("FAIL push1_drain_count: got %0d want 0", count); end
        n_checks++; if (inport_data !== 32'h1F) begin n_fails++; $display("FAIL push1_last_data: got %h want 1f", inport_data); end
        n_checks++; if (underrun !== 1'b0) begin n_fails++; $display("FAIL push1_underrun: got %b want 0", underrun); end
    endtask

    task automatic test_full();
        push_word(32'hA); push_word(32'hB); push_word(32'hC); push_word(32'hD);
        n_checks++; if (ext_if.ext_ready !== 1'b0) begin n_fails++; $display("FAIL full_ready: got %b want 0", ext_if.ext_ready); end
        n_checks++; if (count !== 3'd4) begin n_fails++; $display("FAIL full_count: got %0d want 4", count); end
        ext_if.ext_valid = 1'b1; ext_if.ext_data = 32'hE;
        step();
        n_checks++; if (count !== 3'd4) begin n_fails++; $display("FAIL full_reject_count: got %0d want 4", count); end
        rd_strobe = 1'b1;
        step();
        n_checks++; if (inport_data !== 32'hA) begin n_fails++; $display("FAIL full_strobe1_data: got %h want a", inport_data); end
        step();
        n_checks++; if (inport_data !== 32'hA) begin n_fails++; $display("FAIL full_strobe2_data: got %h want a", inport_data); end
        n_checks++; if (count !== 3'd4) begin n_fails++; $display("FAIL full_strobe_count: got %0d want 4", count); end
        rd_strobe = 1'b0;
        step();
        n_checks++; if (inport_data !== 32'hB) begin n_fails++; $display("FAIL full_retire_data: got %h want b", inport_data); end
        n_checks++; if (count !== 3'd3) begin n_fails++; $display("FAIL full_retire_count: got %0d want 3", count); end
        n_checks++; if (ext_if.ext_ready !== 1'b1) begin n_fails++; $display("FAIL full_retire_ready: got %b want 1", ext_if.ext_ready); end
        step();
        ext_if.ext_valid = 1'b0;
        n_checks++; if (count !== 3'd4) begin n_fails++; $display("FAIL full_late_push_count: got %0d want 4", count); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_head [6];
        logic [31:0] q [$];
        logic [31:0] next_word;
        logic        pushing;
        exp_head = '{32'hB, 32'hC, 32'hD, 32'hE, 32'h100, 32'h101};
        q = '{32'hB, 32'hC, 32'hD, 32'hE};
        next_word = 32'h100;
        for (int i = 0; i < 6; i++) begin
            rd_strobe = 1'b1;
            pushing = (q.size() < 4);
            ext_if.ext_valid = pushing;
            ext_if.ext_data  = next_word;
            step();
            ext_if.ext_valid = 1'b0;
            if (pushing) begin q.push_back(next_word); next_word = next_word + 32'd1; end
            n_checks++; if (count !== 3'(q.size())) begin n_fails++; $display("FAIL wrap_count_a[%0d]: got %0d want %0d", i, count, q.size()); end
            n_checks++; if (inport_data !== exp_head[i]) begin n_fails++; $display("FAIL wrap_head_a[%0d]: got %h want %h", i, inport_data, exp_head[i]); end
            step();
            n_checks++; if (inport_data !== exp_head[i]) begin n_fails++; $display("FAIL wrap_head_b[%0d]: got %h want %h", i, inport_data, exp_head[i]); end
            rd_strobe = 1'b0;
            step();
            void'(q.pop_front());
            n_checks++; if (count !== 3'(q.size())) begin n_fails++; $display("FAIL wrap_count_r[%0d]: got %0d want %0d", i, count, q.size()); end
        end
        n_checks++; if (inport_data !== 32'h102) begin n_fails++; $display("FAIL wrap_final_head: got %h want 102", inport_data); end
    endtask

    task automatic test_back_to_back();
        do_strobe(1);
        n_checks++; if (count !== 3'd2) begin n_fails++; $display("FAIL b2b_pre_count: got %0d want 2", count); end
        n_checks++; if (inport_data !== 32'h103) begin n_fails++; $display("FAIL b2b_pre_head: got %h want 103", inport_data); end
        rd_strobe = 1'b1;
        step();
        rd_strobe = 1'b0;
        ext_if.ext_valid = 1'b1; ext_if.ext_data = 32'h77;
        step();
        ext_if.ext_valid = 1'b0;
        n_checks++; if (count !== 3'd2) begin n_fails++; $display("FAIL b2b_count: got %0d want 2", count); end
        n_checks++; if (inport_data !== 32'h104) begin n_fails++; $display("FAIL b2b_head: got %h want 104", inport_data); end
        do_strobe(1);
        n_checks++; if (inport_data !== 32'h77) begin n_fails++; $display("FAIL b2b_next_head: got %h want 77", inport_data); end
    endtask

    task automatic test_underrun();
        do_strobe(1);
        push_word(32'h55);
        do_strobe(1);
        n_checks++; if (count !== 3'd0) begin n_fails++; $display("FAIL ur_pre_count: got %0d want 0", count); end
        n_checks++; if (inport_data !== 32'h55) begin n_fails++; $display("FAIL ur_pre_data: got %h want 55", inport_data); end
        do_strobe(2);
        n_checks++; if (inport_data !== 32'h55) begin n_fails++; $display("FAIL ur_data: got %h want 55", inport_data); end
        n_checks++; if (count !== 3'd0) begin n_fails++; $display("FAIL ur_count: got %0d want 0", count); end
        n_checks++; if (underrun !== 1'b1) begin n_fails++; $display("FAIL ur_flag: got %b want 1", underrun); end
        n_checks++; if (data_avail !== 1'b0) begin n_fails++; $display("FAIL ur_avail: got %b want 0", data_avail); end
        clr_err = 1'b1; step(); clr_err = 1'b0;
        n_checks++; if (underrun !== 1'b0) begin n_fails++; $display("FAIL ur_clear: got %b want 0", underrun); end
        rd_strobe = 1'b1; step();
        rd_strobe = 1'b0; clr_err = 1'b1; step(); clr_err = 1'b0;
        n_checks++; if (underrun !== 1'b1) begin n_fails++; $display("FAIL ur_set_wins: got %b want 1", underrun); end
        clr_err = 1'b1; step(); clr_err = 1'b0;
        rd_strobe = 1'b1; step();
        rd_strobe = 1'b0;
        ext_if.ext_valid = 1'b1; ext_if.ext_data = 32'h66;
        step();
        ext_if.ext_valid = 1'b0;
        n_checks++; if (count !== 3'd1) begin n_fails++; $display("FAIL ur_push_count: got %0d want 1", count); end
        n_checks++; if (underrun !== 1'b1) begin n_fails++; $display("FAIL ur_push_flag: got %b want 1", underrun); end
        n_checks++; if (inport_data !== 32'h66) begin n_fails++; $display("FAIL ur_push_data: got %h want 66", inport_data); end
        do_strobe(1);
        clr_err = 1'b1; step(); clr_err = 1'b0;
        n_checks++; if (count !== 3'd0) begin n_fails++; $display("FAIL ur_drain_count: got %0d want 0", count); end
    endtask

    task automatic test_reset_mid_strobe();
        push_word(32'h31); push_word(32'h32); push_word(32'h33);
        n_checks++; if (count !== 3'd3) begin n_fails++; $display("FAIL rst_pre_count: got %0d want 3", count); end
        rd_strobe = 1'b1;
        step();
        #2 reset = 1'b1;
        #1;
        n_checks++; if (count !== 3'd0) begin n_fails++; $display("FAIL rst_async_count: got %0d want 0", count); end
        n_checks++; if (inport_data !== 32'h0) begin n_fails++; $display("FAIL rst_async_data: got %h want 0", inport_data); end
        n_checks++; if (ext_if.ext_ready !== 1'b1) begin n_fails++; $display("FAIL rst_async_ready: got %b want 1", ext_if.ext_ready); end
        @(negedge clk);
        reset = 1'b0;
        step();
        rd_strobe = 1'b0;
        step(); step();
        n_checks++; if (count !== 3'd0) begin n_fails++; $display("FAIL rst_post_count: got %0d want 0", count); end
        n_checks++; if (underrun !== 1'b0) begin n_fails++; $display("FAIL rst_post_underrun: got %b want 0", underrun); end
        push_word(32'h44);
        do_strobe(1);
        n_checks++; if (inport_data !== 32'h44) begin n_fails++; $display("FAIL rst_rearm_data: got %h want 44", inport_data); end
        n_checks++; if (count !== 3'd0) begin n_fails++; $display("FAIL rst_rearm_count: got %0d want 0", count); end
        n_checks++; if (underrun !== 1'b0) begin n_fails++; $display("FAIL rst_rearm_underrun: got %b want 0", underrun); end
    endtask

    initial begin
        test_reset();
        test_push_one();
        test_full();
        test_wrap();
        test_back_to_back();
        test_underrun();
        test_reset_mid_strobe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/inport_fifo.md
Name: inport_fifo

Overview:
- Input-side peripheral for the CPU's `in` instruction; the counterpart of the out-port path.
- An external producer pushes 32-bit words through a valid/ready handshake into a small FIFO.
- The datapath's inport_ext_input reads the head word.
- The control unit's inport_out strobe retires that word when the strobe deasserts, so one `in` instruction consumes exactly one word regardless of how many cycles the strobe is held.

Parameters:
DATA_WIDTH, 32, width of each stored word and of inport_data
DEPTH, 4, number of FIFO entries; must be a power of 2, at least 2
ADDR_WIDTH, 2, log2(DEPTH); pointer width

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
ext_valid  input  1  producer has a word on ext_data
ext_data  input  DATA_WIDTH  producer word
ext_ready  output  1  FIFO can accept a word this cycle
rd_strobe  input  1  from control unit (same signal as datapath inport_out); high while the CPU samples the in-port
clr_err  input  1  synchronous clear of the underrun flag
inport_data  output  DATA_WIDTH  drives datapath inport_ext_input
data_avail  output  1  FIFO non-empty
count  output  ADDR_WIDTH+1  number of stored words, 0..DEPTH
underrun  output  1  sticky; a read retired while the FIFO was empty

Behaviour:
Reset (asynchronous, any time, including mid-handshake or while rd_strobe is high):
- wr_ptr, rd_ptr, count, last_data, rd_strobe_q and underrun all go to 0.
- Outputs after reset: ext_ready=1, data_avail=0, inport_data=0, count=0, underrun=0.
- Storage array contents are don't-care.

Handshake and push:
- ext_ready = (count != DEPTH); combinational from registered count only, never from ext_valid.
- Push occurs when ext_valid && ext_ready at a rising edge: mem[wr_ptr] <= ext_data, wr_ptr increments modulo DEPTH (wraps DEPTH-1 to 0).
- When full, ext_valid is ignored and no state changes; the producer must hold its data until ready.

Read side:
- rd_strobe_q is a register tracking rd_strobe.
- Retire event = rd_strobe_q && !rd_strobe, i.e. the first cycle after the strobe falls.
- While rd_strobe is high there is no state change on the read side; inport_data must stay stable for the whole strobe window.
- inport_data = mem[rd_ptr] when count != 0; otherwise last_data. It is combinational from registers.
- Retire with count != 0: last_data <= mem[rd_ptr], and rd_ptr increments modulo DEPTH.
- Retire with count == 0: pointers and last_data unchanged; underrun <= 1.
- Underrun is sticky. clr_err clears it. If a new underrun and clr_err occur in the same cycle, the set wins.

Count update:
- push only: +1
- retire only (non-empty): -1
- push and retire in the same cycle: unchanged, both pointers advance
- Full with a retire in the same cycle: no push that cycle, since ext_ready was 0; the push completes next cycle.
- Empty with a push and a retire in the same cycle: the retire is an underrun because count was 0. The pushed word is kept and count becomes 1.

Other rules:
- data_avail = (count != 0).
- A push is visible on inport_data one cycle after its accepting edge when the FIFO was empty.
- A rising edge of rd_strobe alone does nothing.
- A strobe held for N cycles retires exactly one word.

Test Plan:
- Reset release, then push 0x1F with ext_valid high for one cycle -> next cycle count=1, data_avail=1, inport_data=0x0000001F, ext_ready=1.
- Push 0xA, 0xB, 0xC, 0xD back-to-back, then drive 0xE -> ext_ready=0 after the 4th push, count=4, 0xE not accepted. Pulse rd_strobe for 2 cycles -> inport_data=0xA throughout the pulse, then 0xB. 0xE is accepted the cycle after ext_ready returns to 1, count=4.
- Issue six retires with 2-cycle strobes and pushes interleaved to force wr_ptr/rd_ptr wraparound -> words emerge in FIFO order with no loss or duplication, count consistent at every edge.
- Empty FIFO, last retired word 0x55 -> rd_strobe pulse leaves inport_data=0x55, count=0, underrun=1. Assert clr_err for one cycle -> underrun=0.
- Push and retire in the same cycle with count=2 -> count stays 2, both pointers advance, head becomes the next-oldest word.
- Assert reset asynchronously mid-strobe with count=3 -> immediately count=0, inport_data=0, ext_ready=1. After release, strobe deassertion does not retire anything and does not set underrun.
